contrast_level_ctrl: RTL and testbench

Debounced push-button controller that produces the 4-bit contrast level consumed by the RGB contrast stage. Two active-low keys step the level up or down, with auto-repeat while held and a press-both restore to default. The new level is committed only at the start of vertical sync, so contrast never changes mid-frame.

---
 rtl/contrast_level_ctrl_if.sv | 18 +
 rtl/contrast_level_ctrl.sv | 174 +++++++++++++++++
 tb/tb_contrast_level_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/contrast_level_ctrl_if.sv
// rtl/contrast_level_ctrl_if.sv - key, vsync and contrast level signals of contrast_level_ctrl
interface contrast_level_ctrl_if;
    logic       iKEY_UP;
    logic       iKEY_DN;
    logic       iVSYNC;
    logic [3:0] oContrast_Level;
    logic       oLevel_Pending;

    modport master (
        output iKEY_UP, iKEY_DN, iVSYNC,
        input  oContrast_Level, oLevel_Pending
    );

    modport slave (
        input  iKEY_UP, iKEY_DN, iVSYNC,
        output oContrast_Level, oLevel_Pending
    );
endinterface

// File: rtl/contrast_level_ctrl.sv
// rtl/contrast_level_ctrl.sv - debounced up/down contrast level with auto-repeat and vsync-aligned commit
module contrast_level_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         REPEAT_DELAY    = 25000000,
    parameter int         REPEAT_RATE     = 5000000,
    parameter logic [3:0] RESET_LEVEL     = 4'd8
) (
    input logic                  iCLK,
    input logic                  iRST_N,
    contrast_level_ctrl_if.slave bus
);
    localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

    typedef enum logic [2:0] {IDLE, UP_DLY, UP_RPT, DN_DLY, DN_RPT, BOTH} state_t;

    logic           up_s1_q, up_s2_q, dn_s1_q, dn_s2_q;
    logic           vs_s1_q, vs_s2_q, vs_s3_q;
    logic           up_deb_q, up_deb_d, dn_deb_q, dn_deb_d;
    logic           up_prev_q, dn_prev_q;
    logic [DBW-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;

    state_t         state_q;
    logic [RCW-1:0] rpt_cnt_q;
    logic [3:0]     target_q, level_q;
    logic           pending_q;

    logic           up_held, dn_held, up_evt, dn_evt, vs_fall;
    logic [3:0]     target_inc, target_dec;

    // Counters run only while the synced key disagrees with its debounced state.
    always_comb begin
        up_cnt_d = '0;
        up_deb_d = up_deb_q;
        if (up_s2_q != up_deb_q) begin
            if (up_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                up_deb_d = up_s2_q;
            end else begin
                up_cnt_d = up_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        dn_cnt_d = '0;
        dn_deb_d = dn_deb_q;
        if (dn_s2_q != dn_deb_q) begin
            if (dn_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                dn_deb_d = dn_s2_q;
            end else begin
                dn_cnt_d = dn_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            up_s1_q   <= 1'b1;
            up_s2_q   <= 1'b1;
            dn_s1_q   <= 1'b1;
            dn_s2_q   <= 1'b1;
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vs_s3_q   <= 1'b1;
            up_deb_q  <= 1'b1;
            dn_deb_q  <= 1'b1;
            up_prev_q <= 1'b1;
            dn_prev_q <= 1'b1;
            up_cnt_q  <= '0;
            dn_cnt_q  <= '0;
        end else begin
            up_s1_q   <= bus.iKEY_UP;
            up_s2_q   <= up_s1_q;
            dn_s1_q   <= bus.iKEY_DN;
            dn_s2_q   <= dn_s1_q;
            vs_s1_q   <= bus.iVSYNC;
            vs_s2_q   <= vs_s1_q;
            vs_s3_q   <= vs_s2_q;
            up_deb_q  <= up_deb_d;
            dn_deb_q  <= dn_deb_d;
            up_prev_q <= up_deb_q;
            dn_prev_q <= dn_deb_q;
            up_cnt_q  <= up_cnt_d;
            dn_cnt_q  <= dn_cnt_d;
        end
    end

    // Keys are active-low; a step needs a released-to-pressed transition.
    assign up_held    = ~up_deb_q;
    assign dn_held    = ~dn_deb_q;
    assign up_evt     = ~up_deb_q & up_prev_q;
    assign dn_evt     = ~dn_deb_q & dn_prev_q;
    assign vs_fall    = ~vs_s2_q & vs_s3_q;
    assign target_inc = (target_q == 4'hF) ? target_q : target_q + 4'd1;
    assign target_dec = (target_q == 4'h0) ? target_q : target_q - 4'd1;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
            target_q  <= RESET_LEVEL;
            level_q   <= RESET_LEVEL;
            pending_q <= 1'b0;
        end else begin
            pending_q <= (target_q != level_q);
            if (vs_fall) begin
                level_q <= target_q;
            end
            case (state_q)
                IDLE: begin
                    rpt_cnt_q <= '0;
                    if (up_evt && dn_evt) begin
                        target_q <= RESET_LEVEL;
                        state_q  <= BOTH;
                    end else if (up_evt) begin
                        target_q <= target_inc;
                        state_q  <= UP_DLY;
                    end else if (dn_evt) begin
                        target_q <= target_dec;
                        state_q  <= DN_DLY;
                    end
                end
                UP_DLY, UP_RPT: begin
                    if (!up_held) begin
                        state_q   <= IDLE;
                        rpt_cnt_q <= '0;
                    end else if (dn_held) begin
                        target_q  <= RESET_LEVEL;
                        state_q   <= BOTH;
                        rpt_cnt_q <= '0;
                    end else if ((state_q == UP_DLY && rpt_cnt_q == RCW'(REPEAT_DELAY - 1)) ||
                                 (state_q == UP_RPT && rpt_cnt_q == RCW'(REPEAT_RATE - 1))) begin
                        target_q  <= target_inc;
                        state_q   <= UP_RPT;
                        rpt_cnt_q <= '0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
                end
                DN_DLY, DN_RPT: begin
                    if (!dn_held) begin
                        state_q   <= IDLE;
                        rpt_cnt_q <= '0;
                    end else if (up_held) begin
                        target_q  <= RESET_LEVEL;
                        state_q   <= BOTH;
                        rpt_cnt_q <= '0;
                    end else if ((state_q == DN_DLY && rpt_cnt_q == RCW'(REPEAT_DELAY - 1)) ||
                                 (state_q == DN_RPT && rpt_cnt_q == RCW'(REPEAT_RATE - 1))) begin
                        target_q  <= target_dec;
                        state_q   <= DN_RPT;
                        rpt_cnt_q <= '0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
                end
                BOTH: begin
                    rpt_cnt_q <= '0;
                    if (!up_held && !dn_held) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rpt_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.oContrast_Level = level_q;
    assign bus.oLevel_Pending  = pending_q;
endmodule

// File: tb/tb_contrast_level_ctrl.sv
// tb/tb_contrast_level_ctrl.sv - randomized self-checking bench for contrast_level_ctrl
module tb_contrast_level_ctrl;
    localparam int DEB   = 4;
    localparam int DELAY = 20;
    localparam int RATE  = 8;
    localparam int RL    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_up = 1'b1;
    logic key_dn = 1'b1;
    logic vsync = 1'b1;
    bit   rand_vs = 1'b0;

    int checks = 0;
    int errors = 0;

    contrast_level_ctrl_if bus_if ();
    assign bus_if.iKEY_UP = key_up;
    assign bus_if.iKEY_DN = key_dn;
    assign bus_if.iVSYNC  = vsync;

    contrast_level_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_RATE    (RATE),
        .RESET_LEVEL    (4'(RL))
    ) dut (
        .iCLK  (clk),
        .iRST_N(rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Reference: raw input histories, sliding-window debounce, arithmetic repeat schedule.
    logic [15:0] hu, hd, hv;
    bit du_cur, du_prev, dd_cur, dd_prev;
    int m_target, m_level, mode, t0, k;
    bit m_pend;

    function automatic bit win_flip(logic [15:0] h, bit cur);
        for (int i = 1; i <= DEB; i++) begin
            if (h[i] == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit is_rep(int d);
        return (d == DELAY) || (d > DELAY && ((d - DELAY) % RATE) == 0);
    endfunction

    task automatic model_reset();
        hu = '1; hd = '1; hv = '1;
        du_cur = 1; du_prev = 1; dd_cur = 1; dd_prev = 1;
        m_target = RL; m_level = RL; m_pend = 0; mode = 0; t0 = 0; k = 0;
    endtask

    task automatic model_step();
        int  old_t, old_l;
        bit  up_evt, dn_evt, up_h, dn_h, nu, nd;
        old_t  = m_target;
        old_l  = m_level;
        up_h   = !du_cur;
        dn_h   = !dd_cur;
        up_evt = !du_cur && du_prev;
        dn_evt = !dd_cur && dd_prev;
        case (mode)
            0: begin
                if (up_evt && dn_evt) begin m_target = RL; mode = 3; end
                else if (up_evt) begin m_target = (m_target < 15) ? m_target + 1 : 15; mode = 1; t0 = k; end
                else if (dn_evt) begin m_target = (m_target > 0) ? m_target - 1 : 0; mode = 2; t0 = k; end
            end
            1: begin
                if (!up_h) mode = 0;
                else if (dn_h) begin m_target = RL; mode = 3; end
                else if (is_rep(k - t0)) m_target = (m_target < 15) ? m_target + 1 : 15;
            end
            2: begin
                if (!dn_h) mode = 0;
                else if (up_h) begin m_target = RL; mode = 3; end
                else if (is_rep(k - t0)) m_target = (m_target > 0) ? m_target - 1 : 0;
            end
            default: if (!up_h && !dn_h) mode = 0;
        endcase
        if (hv[1] == 1'b0 && hv[2] == 1'b1) m_level = old_t;
        m_pend  = (old_t != old_l);
        nu      = win_flip(hu, du_cur) ? !du_cur : du_cur;
        nd      = win_flip(hd, dd_cur) ? !dd_cur : dd_cur;
        du_prev = du_cur; du_cur = nu;
        dd_prev = dd_cur; dd_cur = nd;
        hu = {hu[14:0], key_up};
        hd = {hd[14:0], key_dn};
        hv = {hv[14:0], vsync};
        k++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            #1;
            checks++;
            if (bus_if.oContrast_Level !== 4'(m_level)) begin
                errors++;
                $display("FAIL level t=%0t got %0d expected %0d", $time, bus_if.oContrast_Level, m_level);
            end
            checks++;
            if (bus_if.oLevel_Pending !== m_pend) begin
                errors++;
                $display("FAIL pending t=%0t got %0d expected %0d", $time, bus_if.oLevel_Pending, m_pend);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_vs) begin
                repeat ($urandom_range(10, 40)) @(negedge clk);
                vsync = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                vsync = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input bit up, input int hold);
        if (up) key_up = 1'b0; else key_dn = 1'b0;
        cyc(hold);
        key_up = 1'b1;
        key_dn = 1'b1;
        cyc(10);
    endtask

    task automatic vs_pulse();
        vsync = 1'b0;
        cyc(3);
        vsync = 1'b1;
        cyc(3);
    endtask

    initial begin
        cyc(3);
        chk("reset_level", int'(bus_if.oContrast_Level), 8);
        chk("reset_pending", int'(bus_if.oLevel_Pending), 0);
        rst_n = 1'b1;
        cyc(5);

        // single step: target at edge 7, pending at edge 8, commit on 3rd edge
        key_up = 1'b0;
        repeat (7) @(posedge clk);
        #1 chk("step_pend_e7", int'(bus_if.oLevel_Pending), 0);
        @(posedge clk);
        #1 chk("step_pend_e8", int'(bus_if.oLevel_Pending), 1);
        cyc(2);
        key_up = 1'b1;
        cyc(10);
        vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("commit_e2", int'(bus_if.oContrast_Level), 8);
        @(posedge clk);
        #1 chk("commit_e3", int'(bus_if.oContrast_Level), 9);
        chk("model_commit_e3", m_level, 9);
        cyc(1);
        vsync = 1'b1;
        cyc(5);

        // bounce rejection
        for (int i = 0; i < 15; i++) begin
            key_dn = ~key_dn;
            cyc(2);
        end
        key_dn = 1'b1;
        cyc(10);
        chk("bounce_pending", int'(bus_if.oLevel_Pending), 0);
        chk("model_bounce_target", m_target, 9);

        // auto-repeat to saturation
        key_up = 1'b0;
        cyc(120);
        key_up = 1'b1;
        cyc(10);
        chk("rpt_pending", int'(bus_if.oLevel_Pending), 1);
        chk("model_rpt_target", m_target, 15);
        vs_pulse();
        chk("rpt_level", int'(bus_if.oContrast_Level), 15);

        // walk down to 3, then press-both restore
        for (int i = 0; i < 12; i++) tap(1'b0, 10);
        vs_pulse();
        chk("down_level", int'(bus_if.oContrast_Level), 3);
        key_dn = 1'b0;
        cyc(12);
        key_up = 1'b0;
        cyc(40);
        key_up = 1'b1;
        key_dn = 1'b1;
        cyc(15);
        vs_pulse();
        chk("both_level", int'(bus_if.oContrast_Level), 8);
        chk("model_both_level", m_level, 8);
        tap(1'b1, 10);
        vs_pulse();
        chk("after_both_up", int'(bus_if.oContrast_Level), 9);

        // mid-frame step held until vsync
        tap(1'b1, 10);
        cyc(30);
        chk("midframe_level", int'(bus_if.oContrast_Level), 9);
        chk("midframe_pending", int'(bus_if.oLevel_Pending), 1);
        vs_pulse();
        chk("midframe_commit", int'(bus_if.oContrast_Level), 10);

        // async reset mid-repeat
        tap(1'b1, 10);
        vs_pulse();
        key_up = 1'b0;
        cyc(40);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_level", int'(bus_if.oContrast_Level), 8);
        chk("async_rst_pending", int'(bus_if.oLevel_Pending), 0);
        key_up = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);

        // randomized phase
        rand_vs = 1'b1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: cyc($urandom_range(1, 20));
                1: tap(1'b1, $urandom_range(1, 60));
                2: tap(1'b0, $urandom_range(1, 60));
                3: begin
                    key_up = 1'b0;
                    cyc($urandom_range(0, 5));
                    key_dn = 1'b0;
                    cyc($urandom_range(5, 40));
                    key_up = 1'b1;
                    cyc($urandom_range(0, 5));
                    key_dn = 1'b1;
                    cyc(10);
                end
                default: tap($urandom_range(0, 1) == 1, $urandom_range(1, 3));
            endcase
        end
        rand_vs = 1'b0;
        cyc(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
